dec_scan_ctrl: RTL and testbench
================================

# dec_scan_ctrl

Time-multiplexed scan sequencer that generates the 3-bit select and the enable for the downstream 3-to-8 one-hot decoder, stepping through slots 0..last_idx for multiplexed display/row driving. Each slot is driven for a programmable number of cycles, followed by a blanking gap with enable low to suppress ghosting between slots. Start/stop control and a frame-complete pulse let higher-level logic synchronise data updates to frame boundaries.

## Interface
- DIV, 1000, cycles the enable is held high per slot (≥1)
- BLANK, 4, cycles the enable is held low after each slot (≥0)
- CNT_W, 16, slot/blank counter width (must hold max(DIV, BLANK)-1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset: synchronous, active-low
- start  input  1  begin scanning (sampled only in IDLE)
- stop  input  1  request halt at end of current frame (one-cycle pulse sufficient)
- last_idx  input  3  highest slot index scanned (0..7)
- sel  output  3  slot index to decoder `in`
- en  output  1  decoder enable
- frame_done  output  1  one-cycle pulse at each frame completion
- busy  output  1  high whenever not IDLE

## Operation
- States: IDLE, DRIVE, BLANK. All outputs registered.
- Reset (rst_n=0 at a rising edge): state=IDLE, sel=0, en=0, frame_done=0, busy=0, counter=0, last_q=0, stop_pend=0. Applies mid-operation too; no frame_done on reset.
- IDLE: en=0. start=1 and stop=0 → latch last_q=last_idx, sel=0, counter=0, go DRIVE. start=1 with stop=1 in same cycle → stay IDLE (stop wins).
- DRIVE: en=1; counter counts 0..DIV-1. At DIV-1: BLANK>0 → go BLANK, counter=0, en=0; BLANK=0 → perform slot advance directly (en stays high).
- BLANK: en=0; counter counts 0..BLANK-1. At BLANK-1 → slot advance.
- Slot advance: sel<last_q → sel+1, go DRIVE. sel==last_q → frame end: sel=0, frame_done=1 for one cycle, re-latch last_q=last_idx; if stop_pend → IDLE (en=0, busy=0, stop_pend cleared), else DRIVE.
- stop while busy sets stop_pend; it never truncates a frame. stop in IDLE without start is ignored.
- start while busy ignored; last_idx changes while busy take effect only at next frame end.
- sel wraps only via last_q compare; never exceeds last_q.

## Timing
- start sampled at edge N → sel=0, en=1, busy=1 from cycle after edge N.
- Per slot: en high exactly DIV cycles, then low exactly BLANK cycles; sel constant across the slot and its blank, changes on the same edge en rises.
- Frame length = (last_q+1)·(DIV+BLANK) cycles.
- frame_done high in the first cycle of the next frame's sel=0 (or the first IDLE cycle when stopping).
- stop honoured at the first frame end after it is sampled; busy falls on that edge.
- Output latency to decoder: zero combinational path; decoder output follows sel/en same cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → sel=0, en=0, busy=0, frame_done=0 throughout; no activity until start after release.
- Basic scan (DIV=4, BLANK=2, last_idx=2): start pulse → en pattern 1111_00 repeating, sel 0,1,2,0…; frame_done pulses every 18 cycles coincident with sel returning to 0.
- Stop mid-frame: stop pulse while sel=1 → scan completes sel=2 slot and blank, frame_done pulses, busy=0, en=0, sel=0; no further en.
- Single slot and no blank (last_idx=0, BLANK=0, DIV=4): en continuously 1, sel=0, frame_done every 4 cycles; last_idx changed to 3 mid-frame → sel 0..3 begins only after next frame_done.
- Simultaneous/ignored events: start+stop same cycle in IDLE → stays IDLE; start pulse while busy at sel=1 → sel sequence unaffected.
- Reset mid-slot: rst_n=0 during DRIVE at sel=2 → next cycle all outputs at reset values, stop_pend cleared; subsequent start restarts at sel=0 with full DIV-cycle slot.

Source files
------------

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: each slot drives en for DIV cycles, then blanks for BLANK cycles.
// Slots 0..last_q form one frame. A stop request finishes the current frame before returning to idle.
module dec_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] last_idx,
  output logic [2:0] sel,
  output logic       en,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic             HAS_BLANK  = (BLANK > 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic             en_q, en_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;
  logic             pend_q, pend_d;
  logic             adv;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    en_d    = en_q;
    fd_d    = 1'b0;
    busy_d  = busy_q;
    pend_d  = pend_q;
    adv     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          sel_d   = 3'd0;
          last_d  = last_idx;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        pend_d = pend_q | stop;
        if (cnt_q == DIV_LAST) begin
          if (HAS_BLANK) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            en_d    = 1'b0;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BLANK: begin
        pend_d = pend_q | stop;
        if (cnt_q == BLANK_LAST) adv = 1'b1;
        else                     cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (adv) begin
      state_d = S_DRIVE;
      cnt_d   = '0;
      en_d    = 1'b1;
      if (sel_q < last_q) begin
        sel_d = sel_q + 3'd1;
      end else begin
        // frame end: last_idx is only picked up here so a frame is never reshaped mid-scan
        sel_d  = 3'd0;
        fd_d   = 1'b1;
        last_d = last_idx;
        if (pend_q || stop) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      last_q  <= 3'd0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Two scan controllers (DIV=4/BLANK=2 and DIV=4/BLANK=0) against a frame-position model.
// Expected outputs are queued before each edge and compared one time unit after it.
module tb_dec_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop;
  logic [2:0] li_a, li_b;
  logic [2:0] sel_a, sel_b;
  logic       en_a, en_b, fd_a, fd_b, busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DIV(4), .BLANK(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .last_idx(li_a),
    .sel(sel_a), .en(en_a), .frame_done(fd_a), .busy(busy_a)
  );

  dec_scan_ctrl #(.DIV(4), .BLANK(0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .last_idx(li_b),
    .sel(sel_b), .en(en_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Model: position within the frame; slot = pos / period, en = (pos % period) < DIV.
  int   per[2] = '{6, 4};
  bit   m_run[2];
  int   m_pos[2];
  int   m_last[2];
  bit   m_pend[2];
  bit   m_fd[2];
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];

  function automatic logic [5:0] model_out(int i);
    logic [2:0] s;
    logic       e;
    if (!m_run[i]) return {3'd0, 1'b0, m_fd[i], 1'b0};
    s = 3'(m_pos[i] / per[i]);
    e = ((m_pos[i] % per[i]) < 4);
    return {s, e, m_fd[i], 1'b1};
  endfunction

  task automatic model_edge(int i);
    int li;
    li = (i == 0) ? int'(li_a) : int'(li_b);
    m_fd[i] = 1'b0;
    if (!rst_n) begin
      m_run[i] = 0; m_pos[i] = 0; m_last[i] = 0; m_pend[i] = 0;
    end else if (!m_run[i]) begin
      if (start && !stop) begin
        m_run[i] = 1; m_pos[i] = 0; m_last[i] = li;
      end
    end else begin
      m_pend[i] = m_pend[i] | stop;
      if (m_pos[i] == (m_last[i] + 1) * per[i] - 1) begin
        m_fd[i] = 1'b1; m_last[i] = li; m_pos[i] = 0;
        if (m_pend[i]) begin m_run[i] = 0; m_pend[i] = 0; end
      end else begin
        m_pos[i]++;
      end
    end
  endtask

  task automatic chk(string tag, logic [5:0] got, logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got={sel,en,fd,busy}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
    @(posedge clk);
    #1;
    chk("dut_a", {sel_a, en_a, fd_a, busy_a}, q_a.pop_front());
    chk("dut_b", {sel_b, en_b, fd_b, busy_b}, q_b.pop_front());
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic bit a_at_slot(int s);
    return m_run[0] && (m_pos[0] / per[0]) == s && (m_pos[0] % per[0]) == 0;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; li_a = 3'd2; li_b = 3'd0;

    // reset held with start asserted
    steps(2);
    rst_n = 1'b1; start = 1'b0;
    steps(3);

    // basic scan on A, single slot without blank on B
    start = 1'b1; step(); start = 1'b0;
    steps(10);
    li_b = 3'd3;
    steps(30);

    // start while busy at sel=1 must be ignored
    for (int k = 0; k < 40 && !a_at_slot(1); k++) step();
    start = 1'b1; step(); start = 1'b0;
    steps(8);

    // stop at sel=1 finishes the frame
    for (int k = 0; k < 40 && !a_at_slot(1); k++) step();
    stop = 1'b1; step(); stop = 1'b0;
    steps(30);
    chk("a_idle_after_stop", {sel_a, en_a, fd_a, busy_a}, 6'b000000);
    chk("b_idle_after_stop", {sel_b, en_b, fd_b, busy_b}, 6'b000000);

    // start and stop together: stays idle
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    steps(4);

    // reset mid-slot with a stop pending; restart must scan more than one frame
    start = 1'b1; step(); start = 1'b0;
    steps(2);
    stop = 1'b1; step(); stop = 1'b0;
    for (int k = 0; k < 40 && !(m_run[0] && (m_pos[0] / per[0]) == 2); k++) step();
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("reset_mid_slot", {sel_a, en_a, fd_a, busy_a}, 6'b000000);
    steps(2);
    start = 1'b1; step(); start = 1'b0;
    steps(40);
    chk("a_still_busy", {5'b00000, busy_a}, 6'b000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
